// File: rtl/tri_edge_scheduler.sv
// -----------------------------------------------------------------------------
// tri_edge_scheduler
//
// Runs one triangle at a time through the shared edge-walker datapath.
// It accepts three (x,y,z) vertices, sorts them by ascending x with a stable
// network, and then issues the edges one after another:
//   E0 = s0->s1, E1 = s1->s2, E2 = s0->s2.
// It waits for the walker's edge_done after each edge. A watchdog aborts the
// triangle when the walker stalls in a WAIT state.
//
// Parameters
//   TIMEOUT : max cycles spent in a WAIT state before abort (0 = no watchdog)
//   CW      : coordinate width of each x, y, z component
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   tri_valid / tri_ready    : triangle request handshake (ready only in IDLE)
//   v1x..v3z                 : raw vertex coordinates, sampled on accept
//   edge_valid / edge_ready  : edge command handshake to the walker
//   edge_x0,y0,z0,x1,y1,z1   : edge endpoints, edge_x0 <= edge_x1
//   edge_id                  : 0 = s0->s1, 1 = s1->s2, 2 = s0->s2
//   edge_dx, edge_vert       : x1 - x0 and (dx == 0)
//   edge_done                : walker finished the current edge (pulse)
//   busy                     : scheduler is not IDLE
//   tri_done                 : triangle completed (pulse)
//   err                      : watchdog abort (pulse)
// -----------------------------------------------------------------------------
module tri_edge_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tri_valid,
    output logic          tri_ready,
    input  logic [CW-1:0] v1x,
    input  logic [CW-1:0] v1y,
    input  logic [CW-1:0] v1z,
    input  logic [CW-1:0] v2x,
    input  logic [CW-1:0] v2y,
    input  logic [CW-1:0] v2z,
    input  logic [CW-1:0] v3x,
    input  logic [CW-1:0] v3y,
    input  logic [CW-1:0] v3z,
    output logic          edge_valid,
    input  logic          edge_ready,
    output logic [CW-1:0] edge_x0,
    output logic [CW-1:0] edge_y0,
    output logic [CW-1:0] edge_x1,
    output logic [CW-1:0] edge_y1,
    output logic [CW-1:0] edge_z0,
    output logic [CW-1:0] edge_z1,
    output logic [1:0]    edge_id,
    output logic [CW-1:0] edge_dx,
    output logic          edge_vert,
    input  logic          edge_done,
    output logic          busy,
    output logic          tri_done,
    output logic          err
);

    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] z;
    } vtx_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SORT   = 3'd1,
        ST_ISSUE0 = 3'd2,
        ST_WAIT0  = 3'd3,
        ST_ISSUE1 = 3'd4,
        ST_WAIT1  = 3'd5,
        ST_ISSUE2 = 3'd6,
        ST_WAIT2  = 3'd7
    } state_t;

    // Compare-exchange halves. A swap happens only on a strictly greater x,
    // so vertices with equal x keep their input order.
    function automatic vtx_t cx_lo(input vtx_t a, input vtx_t b);
        return (a.x > b.x) ? b : a;
    endfunction

    function automatic vtx_t cx_hi(input vtx_t a, input vtx_t b);
        return (a.x > b.x) ? a : b;
    endfunction

    state_t           r_state;
    vtx_t             r_v0, r_v1, r_v2;
    vtx_t             r_s0, r_s1, r_s2;
    logic [CNT_W-1:0] r_wd_cnt;

    logic             r_tri_ready;
    logic             r_busy;
    logic             r_tri_done;
    logic             r_err;
    logic             r_edge_valid;
    vtx_t             r_edge_a;
    vtx_t             r_edge_b;
    logic [1:0]       r_edge_id;
    logic [CW-1:0]    r_edge_dx;
    logic             r_edge_vert;

    vtx_t             w_st1_lo, w_st1_hi, w_st2_lo, w_st2_hi;
    vtx_t             w_s0, w_s1, w_s2;
    vtx_t             w_ld_a, w_ld_b;
    logic [1:0]       w_ld_id;
    logic [CW-1:0]    w_ld_dx;
    logic             w_wd_hit;

    // Three-stage stable sorting network on x: (0,1), (1,2), (0,1).
    always_comb begin
        w_st1_lo = cx_lo(r_v0, r_v1);
        w_st1_hi = cx_hi(r_v0, r_v1);
        w_st2_lo = cx_lo(w_st1_hi, r_v2);
        w_st2_hi = cx_hi(w_st1_hi, r_v2);
        w_s0     = cx_lo(w_st1_lo, w_st2_lo);
        w_s1     = cx_hi(w_st1_lo, w_st2_lo);
        w_s2     = w_st2_hi;
    end

    // Select the payload of the edge that is loaded when leaving this state.
    // In SORT, the sorted vertices come straight from the network.
    always_comb begin
        w_ld_a  = r_s0;
        w_ld_b  = r_s1;
        w_ld_id = 2'd0;
        case (r_state)
            ST_SORT: begin
                w_ld_a  = w_s0;
                w_ld_b  = w_s1;
                w_ld_id = 2'd0;
            end
            ST_WAIT0: begin
                w_ld_a  = r_s1;
                w_ld_b  = r_s2;
                w_ld_id = 2'd1;
            end
            ST_WAIT1: begin
                w_ld_a  = r_s0;
                w_ld_b  = r_s2;
                w_ld_id = 2'd2;
            end
            default: begin
                w_ld_a  = r_s0;
                w_ld_b  = r_s1;
                w_ld_id = 2'd0;
            end
        endcase
        // The sort guarantees b.x >= a.x, so the result is never negative.
        w_ld_dx = w_ld_b.x - w_ld_a.x;
    end

    // Watchdog expiry in the current WAIT cycle.
    always_comb begin
        if (TIMEOUT != 32'sd0) begin
            w_wd_hit = (r_wd_cnt == CNT_W'(TIMEOUT - 32'sd1));
        end else begin
            w_wd_hit = 1'b0;
        end
    end

    // Scheduler FSM with registered outputs and payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_v0         <= '{x: {CW{1'b0}}, y: {CW{1'b0}}, z: {CW{1'b0}}};
            r_v1         <= '{x: {CW{1'b0}}, y: {CW{1'b0}}, z: {CW{1'b0}}};
            r_v2         <= '{x: {CW{1'b0}}, y: {CW{1'b0}}, z: {CW{1'b0}}};
            r_s0         <= '{x: {CW{1'b0}}, y: {CW{1'b0}}, z: {CW{1'b0}}};
            r_s1         <= '{x: {CW{1'b0}}, y: {CW{1'b0}}, z: {CW{1'b0}}};
            r_s2         <= '{x: {CW{1'b0}}, y: {CW{1'b0}}, z: {CW{1'b0}}};
            r_wd_cnt     <= {CNT_W{1'b0}};
            r_tri_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_tri_done   <= 1'b0;
            r_err        <= 1'b0;
            r_edge_valid <= 1'b0;
            r_edge_a     <= '{x: {CW{1'b0}}, y: {CW{1'b0}}, z: {CW{1'b0}}};
            r_edge_b     <= '{x: {CW{1'b0}}, y: {CW{1'b0}}, z: {CW{1'b0}}};
            r_edge_id    <= 2'd0;
            r_edge_dx    <= {CW{1'b0}};
            r_edge_vert  <= 1'b0;
        end else begin
            r_tri_done <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tri_valid && r_tri_ready) begin
                        r_v0        <= '{x: v1x, y: v1y, z: v1z};
                        r_v1        <= '{x: v2x, y: v2y, z: v2z};
                        r_v2        <= '{x: v3x, y: v3y, z: v3z};
                        r_tri_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    r_s0         <= w_s0;
                    r_s1         <= w_s1;
                    r_s2         <= w_s2;
                    r_edge_a     <= w_ld_a;
                    r_edge_b     <= w_ld_b;
                    r_edge_id    <= w_ld_id;
                    r_edge_dx    <= w_ld_dx;
                    r_edge_vert  <= (w_ld_dx == {CW{1'b0}});
                    r_edge_valid <= 1'b1;
                    r_state      <= ST_ISSUE0;
                end
                ST_ISSUE0: begin
                    if (edge_ready) begin
                        r_edge_valid <= 1'b0;
                        r_wd_cnt     <= {CNT_W{1'b0}};
                        r_state      <= ST_WAIT0;
                    end
                end
                ST_ISSUE1: begin
                    if (edge_ready) begin
                        r_edge_valid <= 1'b0;
                        r_wd_cnt     <= {CNT_W{1'b0}};
                        r_state      <= ST_WAIT1;
                    end
                end
                ST_ISSUE2: begin
                    if (edge_ready) begin
                        r_edge_valid <= 1'b0;
                        r_wd_cnt     <= {CNT_W{1'b0}};
                        r_state      <= ST_WAIT2;
                    end
                end
                ST_WAIT0, ST_WAIT1, ST_WAIT2: begin
                    // edge_done beats a simultaneous watchdog expiry.
                    if (edge_done) begin
                        if (r_state == ST_WAIT2) begin
                            r_tri_done  <= 1'b1;
                            r_tri_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_edge_a     <= w_ld_a;
                            r_edge_b     <= w_ld_b;
                            r_edge_id    <= w_ld_id;
                            r_edge_dx    <= w_ld_dx;
                            r_edge_vert  <= (w_ld_dx == {CW{1'b0}});
                            r_edge_valid <= 1'b1;
                            r_state      <= (r_state == ST_WAIT0) ? ST_ISSUE1 : ST_ISSUE2;
                        end
                    end else if (w_wd_hit) begin
                        r_err       <= 1'b1;
                        r_tri_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_edge_valid <= 1'b0;
                    r_tri_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign tri_ready  = r_tri_ready;
    assign busy       = r_busy;
    assign tri_done   = r_tri_done;
    assign err        = r_err;
    assign edge_valid = r_edge_valid;
    assign edge_x0    = r_edge_a.x;
    assign edge_y0    = r_edge_a.y;
    assign edge_z0    = r_edge_a.z;
    assign edge_x1    = r_edge_b.x;
    assign edge_y1    = r_edge_b.y;
    assign edge_z1    = r_edge_b.z;
    assign edge_id    = r_edge_id;
    assign edge_dx    = r_edge_dx;
    assign edge_vert  = r_edge_vert;

endmodule

// File: tb/tb_tri_edge_scheduler.sv
// -----------------------------------------------------------------------------
// Directed bench for tri_edge_scheduler. The main instance uses TIMEOUT = 8.
// A second instance with TIMEOUT = 3 shares all inputs and is used to show
// that backpressure in an ISSUE state never trips the watchdog.
// -----------------------------------------------------------------------------
module tb_tri_edge_scheduler;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic tri_valid, edge_ready, edge_done;
    logic [CW-1:0] v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z;

    logic tri_ready, edge_valid, busy, tri_done, err, edge_vert;
    logic [CW-1:0] edge_x0, edge_y0, edge_z0, edge_x1, edge_y1, edge_z1, edge_dx;
    logic [1:0] edge_id;

    logic b_tri_ready, b_edge_valid, b_busy, b_tri_done, b_err, b_edge_vert;
    logic [CW-1:0] b_x0, b_y0, b_z0, b_x1, b_y1, b_z1, b_dx;
    logic [1:0] b_id;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [31:0] exp_e [3];

    always #5 clk = ~clk;

    // Free-running cycle count for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    tri_edge_scheduler #(.TIMEOUT(8), .CW(CW)) dut (
        .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .v1x(v1x), .v1y(v1y), .v1z(v1z), .v2x(v2x), .v2y(v2y), .v2z(v2z),
        .v3x(v3x), .v3y(v3y), .v3z(v3z),
        .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_x0(edge_x0), .edge_y0(edge_y0), .edge_x1(edge_x1), .edge_y1(edge_y1),
        .edge_z0(edge_z0), .edge_z1(edge_z1), .edge_id(edge_id), .edge_dx(edge_dx),
        .edge_vert(edge_vert), .edge_done(edge_done), .busy(busy),
        .tri_done(tri_done), .err(err)
    );

    tri_edge_scheduler #(.TIMEOUT(3), .CW(CW)) dut_t3 (
        .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(b_tri_ready),
        .v1x(v1x), .v1y(v1y), .v1z(v1z), .v2x(v2x), .v2y(v2y), .v2z(v2z),
        .v3x(v3x), .v3y(v3y), .v3z(v3z),
        .edge_valid(b_edge_valid), .edge_ready(edge_ready),
        .edge_x0(b_x0), .edge_y0(b_y0), .edge_x1(b_x1), .edge_y1(b_y1),
        .edge_z0(b_z0), .edge_z1(b_z1), .edge_id(b_id), .edge_dx(b_dx),
        .edge_vert(b_edge_vert), .edge_done(edge_done), .busy(b_busy),
        .tri_done(b_tri_done), .err(b_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] pay();
        return {1'b0, edge_id, edge_x0, edge_y0, edge_z0, edge_x1, edge_y1, edge_z1,
                edge_dx, edge_vert};
    endfunction

    function automatic logic [31:0] mk(input logic [1:0] id,
                                       input logic [3:0] x0, input logic [3:0] y0,
                                       input logic [3:0] z0, input logic [3:0] x1,
                                       input logic [3:0] y1, input logic [3:0] z1,
                                       input logic [3:0] dx, input logic vt);
        return {1'b0, id, x0, y0, z0, x1, y1, z1, dx, vt};
    endfunction

    task automatic set_v(input logic [3:0] ax, input logic [3:0] ay, input logic [3:0] az,
                         input logic [3:0] bx, input logic [3:0] by, input logic [3:0] bz,
                         input logic [3:0] cx, input logic [3:0] cy, input logic [3:0] cz);
        v1x = ax; v1y = ay; v1z = az;
        v2x = bx; v2y = by; v2z = bz;
        v3x = cx; v3y = cy; v3z = cz;
    endtask

    // Plays the walker for one edge: waits for the command, optionally holds
    // ready low for 'stall' cycles, accepts it, then optionally returns
    // edge_done one cycle later. Returns on a falling edge.
    task automatic do_edge(input int n, input int stall, input bit give_done);
        int w;
        w = 0;
        while (edge_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_val($sformatf("e%0d valid", n), {31'd0, edge_valid}, 32'd1);
        check_val($sformatf("e%0d payload", n), pay(), exp_e[n]);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_val($sformatf("e%0d stall valid/err", n),
                      {30'd0, edge_valid, err | b_err}, 32'd2);
            check_val($sformatf("e%0d stall payload", n), pay(), exp_e[n]);
        end
        edge_ready = 1'b1;
        @(negedge clk);
        edge_ready = 1'b0;
        check_val($sformatf("e%0d valid drop", n), {31'd0, edge_valid}, 32'd0);
        if (give_done) begin
            edge_done = 1'b1;
            @(negedge clk);
            edge_done = 1'b0;
        end
    endtask

    // mode 0: normal, 1: withhold edge_done in WAIT1, 2: reset during WAIT2.
    task automatic run_tri(input int mode, input int stall1);
        int acc;
        int early;
        check_val("tri_ready idle", {31'd0, tri_ready}, 32'd1);
        tri_valid = 1'b1;
        @(negedge clk);
        tri_valid = 1'b0;
        acc = cyc;
        check_val("busy/ready after accept", {30'd0, busy, tri_ready}, 32'd2);
        do_edge(0, 0, 1'b1);
        if (mode == 1) begin
            do_edge(1, 0, 1'b0);
            early = 0;
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                if (err) early++;
            end
            check_val("no early err", early, 32'd0);
            @(negedge clk);
            check_val("timeout err/done/busy/ready",
                      {28'd0, err, tri_done, busy, tri_ready}, 32'b1001);
            @(negedge clk);
            check_val("err single pulse", {30'd0, err, tri_done}, 32'd0);
        end else begin
            do_edge(1, stall1, 1'b1);
            if (mode == 2) begin
                do_edge(2, 0, 1'b0);
                rst = 1'b1;
                #1;
                check_val("mid reset outputs",
                          {27'd0, tri_ready, busy, edge_valid, tri_done, err}, 32'b10000);
                check_val("mid reset payload", pay(), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                edge_done = 1'b1;
                @(negedge clk);
                edge_done = 1'b0;
                check_val("late done ignored",
                          {28'd0, busy, tri_done, err, tri_ready}, 32'b0001);
            end else begin
                do_edge(2, 0, 1'b1);
                check_val("tri_done/busy/ready", {29'd0, tri_done, busy, tri_ready}, 32'b101);
                check_val("latency", cyc - acc, 7 + stall1);
                @(negedge clk);
                check_val("tri_done pulse", {31'd0, tri_done}, 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        tri_valid = 1'b0;
        edge_ready = 1'b0;
        edge_done = 1'b0;
        set_v(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        check_val("reset outputs", {27'd0, tri_ready, busy, edge_valid, tri_done, err}, 32'b10000);
        check_val("reset payload", pay(), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // edge_done while IDLE does nothing.
        edge_done = 1'b1;
        @(negedge clk);
        edge_done = 1'b0;
        @(negedge clk);
        check_val("idle done ignored", {29'd0, busy, tri_done, tri_ready}, 32'b001);

        // Already sorted.
        set_v(4'd1, 4'd2, 4'd0, 4'd5, 4'd7, 4'd0, 4'd9, 4'd3, 4'd0);
        exp_e[0] = mk(2'd0, 4'd1, 4'd2, 4'd0, 4'd5, 4'd7, 4'd0, 4'd4, 1'b0);
        exp_e[1] = mk(2'd1, 4'd5, 4'd7, 4'd0, 4'd9, 4'd3, 4'd0, 4'd4, 1'b0);
        exp_e[2] = mk(2'd2, 4'd1, 4'd2, 4'd0, 4'd9, 4'd3, 4'd0, 4'd8, 1'b0);
        run_tri(0, 0);

        // Reversed input; z follows its vertex.
        set_v(4'd9, 4'd3, 4'd1, 4'd5, 4'd7, 4'd2, 4'd1, 4'd2, 4'd3);
        exp_e[0] = mk(2'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd2, 4'd4, 1'b0);
        exp_e[1] = mk(2'd1, 4'd5, 4'd7, 4'd2, 4'd9, 4'd3, 4'd1, 4'd4, 1'b0);
        exp_e[2] = mk(2'd2, 4'd1, 4'd2, 4'd3, 4'd9, 4'd3, 4'd1, 4'd8, 1'b0);
        run_tri(0, 0);

        // Equal x keeps input order.
        set_v(4'd4, 4'd1, 4'd0, 4'd4, 4'd8, 4'd0, 4'd2, 4'd5, 4'd0);
        exp_e[0] = mk(2'd0, 4'd2, 4'd5, 4'd0, 4'd4, 4'd1, 4'd0, 4'd2, 1'b0);
        exp_e[1] = mk(2'd1, 4'd4, 4'd1, 4'd0, 4'd4, 4'd8, 4'd0, 4'd0, 1'b1);
        exp_e[2] = mk(2'd2, 4'd2, 4'd5, 4'd0, 4'd4, 4'd8, 4'd0, 4'd2, 1'b0);
        run_tri(0, 0);

        // Degenerate: all x equal.
        set_v(4'd3, 4'd1, 4'd1, 4'd3, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3);
        exp_e[0] = mk(2'd0, 4'd3, 4'd1, 4'd1, 4'd3, 4'd2, 4'd2, 4'd0, 1'b1);
        exp_e[1] = mk(2'd1, 4'd3, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd0, 1'b1);
        exp_e[2] = mk(2'd2, 4'd3, 4'd1, 4'd1, 4'd3, 4'd3, 4'd3, 4'd0, 1'b1);
        run_tri(0, 0);

        // Backpressure in ISSUE1; the TIMEOUT = 3 instance must also complete.
        set_v(4'd1, 4'd2, 4'd0, 4'd5, 4'd7, 4'd0, 4'd9, 4'd3, 4'd0);
        exp_e[0] = mk(2'd0, 4'd1, 4'd2, 4'd0, 4'd5, 4'd7, 4'd0, 4'd4, 1'b0);
        exp_e[1] = mk(2'd1, 4'd5, 4'd7, 4'd0, 4'd9, 4'd3, 4'd0, 4'd4, 1'b0);
        exp_e[2] = mk(2'd2, 4'd1, 4'd2, 4'd0, 4'd9, 4'd3, 4'd0, 4'd8, 1'b0);
        run_tri(0, 5);
        check_val("t3 idle after backpressure", {30'd0, b_busy, b_tri_ready}, 32'd1);

        // Watchdog abort in WAIT1, then a normal triangle.
        run_tri(1, 0);
        run_tri(0, 0);

        // Reset during WAIT2, then a normal reversed triangle.
        run_tri(2, 0);
        set_v(4'd9, 4'd3, 4'd1, 4'd5, 4'd7, 4'd2, 4'd1, 4'd2, 4'd3);
        exp_e[0] = mk(2'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd2, 4'd4, 1'b0);
        exp_e[1] = mk(2'd1, 4'd5, 4'd7, 4'd2, 4'd9, 4'd3, 4'd1, 4'd4, 1'b0);
        exp_e[2] = mk(2'd2, 4'd1, 4'd2, 4'd3, 4'd9, 4'd3, 4'd1, 4'd8, 1'b0);
        run_tri(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound in case the run stops making progress.
    initial begin
        #200000;
        $display("FAIL time bound: got expired expected finish");
        $fatal(1, "time bound expired");
    end

endmodule
